// File: rtl/calc_pkg.sv
// Shared calculator definitions: key codes, PS/2 scan constants, state encodings
// and the set-2 scan code to key code map used by the keypad front end.
package calc_pkg;

    localparam logic [3:0] KEY_PLUS  = 4'd10;
    localparam logic [3:0] KEY_MINUS = 4'd11;
    localparam logic [3:0] KEY_MULT  = 4'd12;
    localparam logic [3:0] KEY_ESC   = 4'd13;
    localparam logic [3:0] KEY_ENTER = 4'd14;
    // Never a legal key; marks "unmapped" and "no key held".
    localparam logic [3:0] KEY_NONE  = 4'd15;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_DATA = 2'd1,
        RX_STOP = 2'd2
    } rx_state_t;

    // Bit 0 tracks a pending E0 prefix, bit 1 a pending F0 prefix.
    typedef enum logic [1:0] {
        DEC_MAKE    = 2'b00,
        DEC_EXT     = 2'b01,
        DEC_BRK     = 2'b10,
        DEC_EXT_BRK = 2'b11
    } dec_state_t;

    function automatic logic [3:0] scan_to_key(input logic ext, input logic [7:0] sc);
        logic [3:0] k;
        k = KEY_NONE;
        if (ext) begin
            if (sc == 8'h5A) begin
                k = KEY_ENTER;
            end
        end else begin
            case (sc)
                8'h45, 8'h70: k = 4'd0;
                8'h16, 8'h69: k = 4'd1;
                8'h1E, 8'h72: k = 4'd2;
                8'h26, 8'h7A: k = 4'd3;
                8'h25, 8'h6B: k = 4'd4;
                8'h2E, 8'h73: k = 4'd5;
                8'h36, 8'h74: k = 4'd6;
                8'h3D, 8'h6C: k = 4'd7;
                8'h3E, 8'h75: k = 4'd8;
                8'h46, 8'h7D: k = 4'd9;
                8'h79:        k = KEY_PLUS;
                8'h4E, 8'h7B: k = KEY_MINUS;
                8'h7C:        k = KEY_MULT;
                8'h76:        k = KEY_ESC;
                8'h5A:        k = KEY_ENTER;
                default:      k = KEY_NONE;
            endcase
        end
        return k;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronises the raw lines, samples on ps2_clk
// falling edges, checks start/parity/stop and discards stalled partial frames.
module ps2_rx
    import calc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 50000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_rdy,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    rx_state_t              state_q, state_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   par_q, par_d;
    logic [WD_W-1:0]        wd_q, wd_d;
    logic                   byte_rdy_q, byte_rdy_d;
    logic                   err_q, err_d;

    logic clk_s, data_s, fall, timeout;

    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
        clk_s       = clk_sync_q[SYNC_STAGES-1];
        data_s      = data_sync_q[SYNC_STAGES-1];
        fall        = clk_prev_q & ~clk_s;
        clk_prev_d  = clk_s;

        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        byte_rdy_d = 1'b0;
        err_d      = 1'b0;

        // Watchdog measures cycles since the last falling edge, only mid-frame.
        if (bit_cnt_q == 4'd0 || fall) begin
            wd_d = '0;
        end else begin
            wd_d = wd_q + 1'b1;
        end
        timeout = (bit_cnt_q != 4'd0) && !fall && (wd_q == WD_LAST);

        if (timeout) begin
            state_d   = RX_IDLE;
            bit_cnt_d = 4'd0;
            err_d     = 1'b1;
            wd_d      = '0;
        end else if (fall) begin
            case (state_q)
                RX_IDLE: begin
                    if (!data_s) begin
                        state_d   = RX_DATA;
                        bit_cnt_d = 4'd1;
                        par_d     = 1'b0;
                    end
                end
                RX_DATA: begin
                    if (bit_cnt_q <= 4'd8) begin
                        shift_d = {data_s, shift_q[7:1]};
                    end
                    // Running XOR over data and parity bit must end up odd.
                    par_d     = par_q ^ data_s;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd9) begin
                        state_d = RX_STOP;
                    end
                end
                RX_STOP: begin
                    state_d   = RX_IDLE;
                    bit_cnt_d = 4'd0;
                    if (data_s && par_q) begin
                        byte_rdy_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: begin
                    state_d   = RX_IDLE;
                    bit_cnt_d = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q  <= '0;
            data_sync_q <= '0;
            clk_prev_q  <= 1'b0;
            state_q     <= RX_IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            wd_q        <= '0;
            byte_rdy_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_prev_q  <= clk_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            wd_q        <= wd_d;
            byte_rdy_q  <= byte_rdy_d;
            err_q       <= err_d;
        end
    end

    assign byte_rdy  = byte_rdy_q;
    assign rx_byte   = shift_q;
    assign frame_err = err_q;

endmodule

// File: rtl/ps2_keypad.sv
// Keyboard front end of the calculator: turns received PS/2 bytes into one
// strobed key code per fresh key press, ignoring breaks and typematic repeats.
module ps2_keypad
    import calc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 50000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] key_code,
    output logic        key_valid,
    output logic        frame_err
);

    logic       byte_rdy;
    logic [7:0] rx_byte;
    logic       rx_err;

    ps2_rx #(
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_rx (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .byte_rdy (byte_rdy),
        .rx_byte  (rx_byte),
        .frame_err(rx_err)
    );

    dec_state_t state_q, state_d;
    logic [3:0] key_code_q, key_code_d;
    logic       key_valid_q, key_valid_d;
    logic [3:0] last_make_q, last_make_d;

    logic       ext, brk;
    logic [3:0] code;

    always_comb begin
        state_d     = state_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        last_make_d = last_make_q;

        ext  = (state_q == DEC_EXT) || (state_q == DEC_EXT_BRK);
        brk  = (state_q == DEC_BRK) || (state_q == DEC_EXT_BRK);
        code = scan_to_key(ext, rx_byte);

        if (byte_rdy) begin
            if (rx_byte == SC_EXT) begin
                state_d = brk ? DEC_EXT_BRK : DEC_EXT;
            end else if (rx_byte == SC_BREAK) begin
                state_d = ext ? DEC_EXT_BRK : DEC_BRK;
            end else if (brk) begin
                if (code == last_make_q) begin
                    last_make_d = KEY_NONE;
                end
                state_d = DEC_MAKE;
            end else begin
                state_d = DEC_MAKE;
                // last_make only changes on a new press or its own release,
                // so a second key pressed while one is held still strobes.
                if (code != KEY_NONE && code != last_make_q) begin
                    key_code_d  = code;
                    key_valid_d = 1'b1;
                    last_make_d = code;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= DEC_MAKE;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            last_make_q <= KEY_NONE;
        end else begin
            state_q     <= state_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            last_make_q <= last_make_d;
        end
    end

    assign key_code  = {7'd0, key_code_q};
    assign key_valid = key_valid_q;
    assign frame_err = rx_err;

endmodule

// File: tb/tb_ps2_keypad.sv
// Directed bench for ps2_keypad: drives PS/2 frames bit by bit and checks
// strobes, key codes, latencies, error pulses and reset behaviour.
module tb_ps2_keypad;

    localparam int TO = 2000;
    localparam int Q  = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic        ps2_clk;
    logic        ps2_data;
    logic [10:0] key_code;
    logic        key_valid;
    logic        frame_err;

    ps2_keypad #(
        .TIMEOUT_CYC(TO),
        .SYNC_STAGES(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .key_code (key_code),
        .key_valid(key_valid),
        .frame_err(frame_err)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int kv_code_q[$];
    int kv_cyc_q[$];
    int fe_cyc_q[$];

    always @(negedge clk) begin
        if (key_valid) begin
            kv_code_q.push_back(int'(key_code));
            kv_cyc_q.push_back(cyc);
        end
        if (frame_err) fe_cyc_q.push_back(cyc);
        if (key_valid || frame_err) check("excl", {31'd0, key_valid & frame_err}, 32'd0);
    end

    function automatic int kv_code_at(input int i);
        return (i < kv_code_q.size()) ? kv_code_q[i] : -1;
    endfunction
    function automatic int kv_cyc_at(input int i);
        return (i < kv_cyc_q.size()) ? kv_cyc_q[i] : -1;
    endfunction
    function automatic int fe_cyc_at(input int i);
        return (i < fe_cyc_q.size()) ? fe_cyc_q[i] : -1;
    endfunction

    task automatic clear_log();
        kv_code_q.delete();
        kv_cyc_q.delete();
        fe_cyc_q.delete();
    endtask

    function automatic logic [10:0] frame(input logic [7:0] b, input logic bad_par);
        logic p;
        p = (~^b) ^ bad_par;
        return {1'b1, p, b, 1'b0};
    endfunction

    int last_fall;
    int last_stop;

    // Data changes in the middle of the low phase; edges land on clk negedges.
    task automatic send_bits(input logic [10:0] bits, input int n);
        @(negedge clk);
        ps2_data = bits[0];
        #(2*Q);
        for (int i = 0; i < n; i++) begin
            ps2_clk   = 1'b0;
            last_fall = cyc;
            #(Q);
            ps2_data = (i + 1 < n) ? bits[i+1] : 1'b1;
            #(Q);
            ps2_clk = 1'b1;
            #(2*Q);
        end
        #(400);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par);
        send_bits(frame(b, bad_par), 11);
        last_stop = last_fall;
    endtask

    task automatic settle();
        repeat (20) @(negedge clk);
    endtask

    int s;

    initial begin
        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_code", {21'd0, key_code}, 32'd0);
        check("rst_kv", {31'd0, key_valid}, 32'd0);
        check("rst_fe", {31'd0, frame_err}, 32'd0);
        rst = 1'b0;
        settle();

        // 1: make 2E then break F0 2E
        clear_log();
        send_byte(8'h2E, 1'b0);
        s = last_stop;
        send_byte(8'hF0, 1'b0);
        send_byte(8'h2E, 1'b0);
        settle();
        check("t1_count", kv_code_q.size(), 1);
        check("t1_code", kv_code_at(0), 5);
        check("t1_latency", kv_cyc_at(0) - s, 4);
        check("t1_fe", fe_cyc_q.size(), 0);
        check("t1_hold", {21'd0, key_code}, 32'd5);

        // 2: extended Enter make/break, unmapped E0 4A, then '+'
        clear_log();
        send_byte(8'hE0, 1'b0);
        send_byte(8'h5A, 1'b0);
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h5A, 1'b0);
        settle();
        check("t2_enter_count", kv_code_q.size(), 1);
        check("t2_enter_code", kv_code_at(0), 14);
        clear_log();
        send_byte(8'hE0, 1'b0);
        send_byte(8'h4A, 1'b0);
        send_byte(8'h79, 1'b0);
        settle();
        check("t2_plus_count", kv_code_q.size(), 1);
        check("t2_plus_code", kv_code_at(0), 10);

        // 3: parity error then good frame
        clear_log();
        send_byte(8'h16, 1'b1);
        s = last_stop;
        settle();
        check("t3_fe_count", fe_cyc_q.size(), 1);
        check("t3_fe_latency", fe_cyc_at(0) - s, 3);
        check("t3_no_kv", kv_code_q.size(), 0);
        send_byte(8'h16, 1'b0);
        settle();
        check("t3_code", kv_code_at(0), 1);
        check("t3_count", kv_code_q.size(), 1);

        // 4: stalled partial frame
        clear_log();
        send_bits(frame(8'h3D, 1'b0), 5);
        s = last_fall;
        repeat (TO + 500) @(negedge clk);
        check("t4_fe_count", fe_cyc_q.size(), 1);
        check("t4_fe_time", fe_cyc_at(0) - s, TO + 3);
        check("t4_no_kv", kv_code_q.size(), 0);
        send_byte(8'h3D, 1'b0);
        settle();
        check("t4_code", kv_code_at(0), 7);
        check("t4_count", kv_code_q.size(), 1);
        check("t4_fe_after", fe_cyc_q.size(), 1);

        // 5: typematic repeats
        clear_log();
        send_byte(8'h1E, 1'b0);
        send_byte(8'h1E, 1'b0);
        send_byte(8'h1E, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1E, 1'b0);
        send_byte(8'h1E, 1'b0);
        settle();
        check("t5_count", kv_code_q.size(), 2);
        check("t5_code0", kv_code_at(0), 2);
        check("t5_code1", kv_code_at(1), 2);

        // 6: reset during bit 4 of a frame
        clear_log();
        send_bits(frame(8'h7C, 1'b0), 5);
        rst = 1'b1;
        #1;
        check("t6_rst_code", {21'd0, key_code}, 32'd0);
        check("t6_rst_kv", {31'd0, key_valid}, 32'd0);
        check("t6_rst_fe", {31'd0, frame_err}, 32'd0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (TO + 200) @(negedge clk);
        check("t6_no_fe", fe_cyc_q.size(), 0);
        check("t6_no_kv", kv_code_q.size(), 0);
        send_byte(8'h7C, 1'b0);
        settle();
        check("t6_count", kv_code_q.size(), 1);
        check("t6_code", kv_code_at(0), 12);
        check("t6_fe", fe_cyc_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
